// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg: state encoding and widths shared by the divider sequencer.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'd0,
    DC_RUN   = 2'd1,
    DC_HOLD  = 2'd2,
    DC_DRAIN = 2'd3
  } dc_state_e;

  localparam int DIV_RESULT_W = 64;
  localparam int DIV_OP_W     = 32;

endpackage

`default_nettype wire

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl: EX-stage sequencer driving the iterative divider start/cancel
// handshake, holding the HI/LO result until EX advances. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    div_req_i,
  input  logic                    signed_i,
  input  logic [DIV_OP_W-1:0]     opa_i,
  input  logic [DIV_OP_W-1:0]     opb_i,
  input  logic                    flush_i,
  input  logic                    ex_stall_i,
  output logic                    div_start_o,
  output logic                    div_cancel_o,
  output logic                    div_signed_o,
  output logic [DIV_OP_W-1:0]     div_opa_o,
  output logic [DIV_OP_W-1:0]     div_opb_o,
  input  logic [DIV_RESULT_W-1:0] div_result_i,
  input  logic                    div_ready_i,
  output logic                    stall_req_o,
  output logic                    hilo_we_o,
  output logic [DIV_OP_W-1:0]     hi_o,
  output logic [DIV_OP_W-1:0]     lo_o,
  output logic                    timeout_o
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 40) begin : g_bad_timeout
    $error("div_ctrl: TIMEOUT must be at least 40");
  end

  dc_state_e               state;
  logic [CNT_W-1:0]        wd_cnt;
  logic                    drain_cnt;
  logic [DIV_RESULT_W-1:0] result;
  logic                    wd_last;

  assign wd_last = (wd_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DC_IDLE;
      wd_cnt       <= '0;
      drain_cnt    <= 1'b0;
      result       <= '0;
      div_signed_o <= 1'b0;
      div_opa_o    <= '0;
      div_opb_o    <= '0;
    end else begin
      unique case (state)
        DC_IDLE: begin
          if (div_req_i && !flush_i) begin
            if (opb_i != '0) begin
              div_signed_o <= signed_i;
              div_opa_o    <= opa_i;
              div_opb_o    <= opb_i;
              wd_cnt       <= '0;
              state        <= DC_RUN;
            end else begin
              // Zero divisor never reaches the divider; HI/LO read back as 0.
              result <= '0;
              state  <= DC_HOLD;
            end
          end
        end
        DC_RUN: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (flush_i) begin
            drain_cnt <= 1'b0;
            state     <= DC_DRAIN;
          end else if (div_ready_i) begin
            result <= div_result_i;
            state  <= DC_HOLD;
          end else if (wd_last) begin
            drain_cnt <= 1'b0;
            state     <= DC_DRAIN;
          end
        end
        DC_HOLD: begin
          if (flush_i || !ex_stall_i) begin
            state <= DC_IDLE;
          end
        end
        DC_DRAIN: begin
          // Two cancel cycles cover both the ON->FREE and ZERO->END->FREE exits.
          if (drain_cnt) begin
            state <= DC_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
      endcase
    end
  end

  assign div_start_o  = (state == DC_RUN);
  assign div_cancel_o = (state == DC_DRAIN);
  assign hilo_we_o    = (state == DC_HOLD) && !flush_i;
  assign timeout_o    = (state == DC_RUN) && !flush_i && !div_ready_i && wd_last;
  assign hi_o         = result[DIV_RESULT_W-1:DIV_OP_W];
  assign lo_o         = result[DIV_OP_W-1:0];

  always_comb begin
    stall_req_o = 1'b0;
    if (rst_n) begin
      unique case (state)
        DC_IDLE: stall_req_o = div_req_i && !flush_i;
        DC_RUN:  stall_req_o = 1'b1;
        default: stall_req_o = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire
